regfile_gen: RTL and testbench
==============================

REGFILE_GEN -- requirements
Module: regfile_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning 1 = register 0 reads as zero and ignores writes.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset; synchronous and active-high.
REQ-006 SHALL have port rd_en  input  1  meaning read request for both read ports.
REQ-007 SHALL have ports ra_addr and rb_addr  input  ADDR_W  meaning read addresses for ports A and B.
REQ-008 SHALL have ports ra_data and rb_data  output  DATA_W  meaning registered read data.
REQ-009 SHALL have port rd_valid  output  1  meaning ra_data and rb_data are valid this cycle.
REQ-010 SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_W), wr_data (input, DATA_W) and wr_be (input, DATA_W/8), meaning write strobe, address, data and byte enables.
REQ-011 SHALL have ports dbg_addr (input, ADDR_W) and dbg_data (output, DATA_W), meaning the debug/display read port.
REQ-012 SHALL have port busy  output  1  meaning a clear sweep is in progress.
REQ-013 SHALL have port wr_drop  output  1  meaning sticky flag: a write was rejected.

Function
REQ-014 SHALL implement FSM states CLEAR and READY; rst forces CLEAR with sweep index 0.
REQ-015 SHALL, in CLEAR, write zero to one register per cycle (index 0..DEPTH-1), hold busy=1, then enter READY after index DEPTH-1; the sweep takes exactly DEPTH cycles.
REQ-016 SHALL, in READY, hold busy=0 and accept reads and writes.
REQ-017 SHALL, when wr_en=1 in READY, update only the bytes of wr_addr whose wr_be bit is 1.
REQ-018 SHALL, when ZERO_REG=1, ignore writes to address 0; this is not a drop.
REQ-019 SHALL, when wr_en=1 while busy=1, discard the write and set wr_drop=1 until rst.
REQ-020 SHALL, when rd_en=1 and busy=0 in cycle N, present ra_data and rb_data with rd_valid=1 in cycle N+1 (latency 1).
REQ-021 SHALL drive rd_valid=0 in the cycle after rd_en=0 or busy=1; ra_data and rb_data then hold their previous values.
REQ-022 SHALL bypass a write to a read port: if wr_en is accepted in cycle N at the same address a port reads in cycle N, that port returns the old value merged with the written bytes.
REQ-023 SHALL, when ZERO_REG=1, return 0 for any read of address 0, with or without bypass.
REQ-024 SHALL update dbg_data every cycle with the pre-write contents of dbg_addr (latency 1, no bypass), independent of rd_en and busy.
REQ-025 SHALL, if rst is asserted during CLEAR, restart the sweep at index 0.
REQ-026 SHALL, on rst, discard any read or write presented in the same cycle.

Reset
REQ-027 SHALL, on rst, set ra_data=0, rb_data=0, dbg_data=0, rd_valid=0, wr_drop=0, busy=1 and state=CLEAR.
REQ-028 SHALL NOT reset the storage array directly; storage is zeroed only by the sweep, so it can map to RAM.

Structure
REQ-029 SHALL define the state encoding (CLEAR, READY) and default widths (DATA_W=32, ADDR_W=5) in the shared CPU package.
REQ-030 SHALL use the byte-merge function (old, new, be -> merged) from the same package for both writes and bypass.
REQ-031 SHALL be a single module; no sub-module is required.

Verification
REQ-032 SHALL cover reset/sweep: pulse rst, read all registers after busy falls -> busy high for exactly 32 cycles, all reads return 0.
REQ-033 SHALL cover byte-enable write: write 0xAABBCCDD with be=4'b1111 to r5, then 0x11223344 with be=4'b0101 to r5, then read -> 0xAA22CC44.
REQ-034 SHALL cover bypass: in one cycle write 0xDEADBEEF to r7 with ra_addr=rb_addr=7 and rd_en=1 -> next cycle ra_data=rb_data=0xDEADBEEF and dbg_data(addr 7) shows the old value.
REQ-035 SHALL cover zero register: write 0x12345678 to r0, then read -> 0, and wr_drop stays 0.
REQ-036 SHALL cover drop during sweep: wr_en at cycle 3 of CLEAR -> wr_drop=1 and the target reads 0 after the sweep.
REQ-037 SHALL cover mid-sweep reset: rst at sweep index 20 -> busy stays high 32 more cycles; rd_valid=0 throughout.

Source files
------------

// File: rtl/regfile_gen_pkg.sv
// Shared CPU package: register-file state encoding, default widths and byte-merge helper.
package regfile_gen_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Widest register the merge helper supports; callers zero-extend and truncate.
    localparam int unsigned MERGE_W    = 512;
    localparam int unsigned MERGE_BE_W = MERGE_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Replace the bytes of old_val whose enable bit is set with the matching bytes of new_val.
    function automatic logic [MERGE_W-1:0] merge_bytes(
        input logic [MERGE_W-1:0]    old_val,
        input logic [MERGE_W-1:0]    new_val,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(MERGE_BE_W); i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_gen_if.sv
// Register-file bus: two read ports, one byte-enabled write port, debug port and status.
interface regfile_gen_if
    import regfile_gen_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic                  rd_en;
    logic [ADDR_W-1:0]     ra_addr;
    logic [ADDR_W-1:0]     rb_addr;
    logic [DATA_W-1:0]     ra_data;
    logic [DATA_W-1:0]     rb_data;
    logic                  rd_valid;

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;

    logic [ADDR_W-1:0]     dbg_addr;
    logic [DATA_W-1:0]     dbg_data;

    logic                  busy;
    logic                  wr_drop;

    modport master (
        output rd_en, ra_addr, rb_addr, wr_en, wr_addr, wr_data, wr_be, dbg_addr,
        input  ra_data, rb_data, rd_valid, dbg_data, busy, wr_drop
    );

    modport slave (
        input  rd_en, ra_addr, rb_addr, wr_en, wr_addr, wr_data, wr_be, dbg_addr,
        output ra_data, rb_data, rd_valid, dbg_data, busy, wr_drop
    );

endinterface

// File: rtl/regfile_gen.sv
// Two-read / one-write register file with write bypass, debug port and a zeroing sweep
// after reset. Storage has no reset so it can map onto RAM.
module regfile_gen
    import regfile_gen_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_gen_if.slave   bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] ra_data_q;
    logic [DATA_W-1:0] rb_data_q;
    logic [DATA_W-1:0] dbg_data_q;
    logic              rd_valid_q;
    logic              busy_q;
    logic              wr_drop_q;

    logic              wr_accept;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] ra_next;
    logic [DATA_W-1:0] rb_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Write acceptance, byte merge and bypassed read values.
    always_comb begin
        wr_accept = !rst && (state_q == READY) && bus.wr_en &&
                    !(ZERO_REG && (bus.wr_addr == '0));
        wr_merged = DATA_W'(merge_bytes(MERGE_W'(mem[bus.wr_addr]), MERGE_W'(bus.wr_data),
                                        MERGE_BE_W'(bus.wr_be)));

        // A hit on the write address means mem[ra] is the write's old value, so the
        // already-merged word is exactly the bypass result.
        if (ZERO_REG && (bus.ra_addr == '0)) begin
            ra_next = '0;
        end else if (wr_accept && (bus.wr_addr == bus.ra_addr)) begin
            ra_next = wr_merged;
        end else begin
            ra_next = mem[bus.ra_addr];
        end

        if (ZERO_REG && (bus.rb_addr == '0)) begin
            rb_next = '0;
        end else if (wr_accept && (bus.wr_addr == bus.rb_addr)) begin
            rb_next = wr_merged;
        end else begin
            rb_next = mem[bus.rb_addr];
        end
    end

    // Storage write mux: sweep zeroing in CLEAR, accepted writes in READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = wr_merged;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = '0;
            end else begin
                mem_we    = wr_accept;
            end
        end
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Sweep/ready FSM with registered read, debug and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            idx_q      <= '0;
            ra_data_q  <= '0;
            rb_data_q  <= '0;
            dbg_data_q <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
            wr_drop_q  <= 1'b0;
        end else begin
            dbg_data_q <= mem[bus.dbg_addr];
            unique case (state_q)
                CLEAR: begin
                    rd_valid_q <= 1'b0;
                    if (bus.wr_en) begin
                        wr_drop_q <= 1'b1;
                    end
                    idx_q <= idx_q + ADDR_W'(1);
                    if (&idx_q) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    rd_valid_q <= bus.rd_en;
                    if (bus.rd_en) begin
                        ra_data_q <= ra_next;
                        rb_data_q <= rb_next;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign bus.ra_data  = ra_data_q;
    assign bus.rb_data  = rb_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.dbg_data = dbg_data_q;
    assign bus.busy     = busy_q;
    assign bus.wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_gen.sv
// Bench for regfile_gen: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_gen;
    import regfile_gen_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_gen_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_gen #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .ZERO_REG (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [DW-1:0] mem_m [DEPTH];
    int            sweep_left = 0;
    int            sweep_pos  = 0;
    bit            started    = 0;
    bit            mem_known  = 0;
    bit            dbg_chk    = 0;
    logic [DW-1:0] exp_ra     = '0;
    logic [DW-1:0] exp_rb     = '0;
    logic [DW-1:0] exp_dbg    = '0;
    bit            exp_valid  = 0;
    bit            exp_drop   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr, input bit wr_ok,
                                                 input logic [DW-1:0] merged);
        if (addr == 0) return '0;
        if (wr_ok && addr == bus.wr_addr) return merged;
        return mem_m[addr];
    endfunction

    // Apply the rules of one rising edge to the model, using the inputs seen at that edge.
    task automatic model_edge();
        logic [DW-1:0] merged;
        bit            wr_ok;
        if (rst) begin
            started    = 1;
            sweep_left = DEPTH;
            sweep_pos  = 0;
            exp_drop   = 0;
            exp_ra     = '0;
            exp_rb     = '0;
            exp_dbg    = '0;
            exp_valid  = 0;
            dbg_chk    = 1;
        end else if (started) begin
            exp_dbg = mem_m[bus.dbg_addr];
            dbg_chk = mem_known;
            if (sweep_left > 0) begin
                if (bus.wr_en) exp_drop = 1;
                exp_valid = 0;
                mem_m[sweep_pos] = '0;
                sweep_pos++;
                sweep_left--;
                if (sweep_left == 0) mem_known = 1;
            end else begin
                wr_ok  = bus.wr_en && (bus.wr_addr != 0);
                merged = mem_m[bus.wr_addr];
                for (int b = 0; b < int'(DW / 8); b++) begin
                    if (bus.wr_be[b]) merged[8*b +: 8] = bus.wr_data[8*b +: 8];
                end
                exp_valid = bus.rd_en;
                if (bus.rd_en) begin
                    exp_ra = model_read(bus.ra_addr, wr_ok, merged);
                    exp_rb = model_read(bus.rb_addr, wr_ok, merged);
                end
                if (wr_ok) mem_m[bus.wr_addr] = merged;
            end
        end
    endtask

    task automatic compare();
        if (started) begin
            check_eq("busy", bus.busy, sweep_left > 0);
            check_eq("rd_valid", bus.rd_valid, exp_valid);
            check_eq("wr_drop", bus.wr_drop, exp_drop);
            check_eq("ra_data", bus.ra_data, exp_ra);
            check_eq("rb_data", bus.rb_data, exp_rb);
            if (dbg_chk) check_eq("dbg_data", bus.dbg_data, exp_dbg);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        rst          = 1'b0;
        bus.rd_en    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.ra_addr  = '0;
        bus.rb_addr  = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_be    = '0;
        bus.dbg_addr = '0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be   = be;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        bus.rd_en   = 1'b1;
        bus.ra_addr = a;
        bus.rb_addr = b;
        step();
        bus.rd_en   = 1'b0;
    endtask

    // Count cycles until busy drops, bounded so a stuck sweep cannot hang the run.
    task automatic wait_sweep(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        idle_inputs();
        rst = 1'b1;

        // Reset and full sweep: busy high for exactly DEPTH cycles, everything reads zero.
        step();
        rst = 1'b0;
        wait_sweep(n);
        check_eq("sweep_len", n, DEPTH);
        for (int a = 0; a < int'(DEPTH); a += 2) begin
            read(AW'(a), AW'(a + 1));
            check_eq("swept_a", bus.ra_data, 0);
            check_eq("swept_b", bus.rb_data, 0);
        end

        // Byte-enable merge.
        write(5'd5, 32'hAABBCCDD, 4'b1111);
        write(5'd5, 32'h11223344, 4'b0101);
        read(5'd5, 5'd5);
        check_eq("be_merge", bus.ra_data, 32'hAA22CC44);

        // Write bypass to both ports; debug port shows the pre-write value.
        write(5'd7, 32'h01020304, 4'b1111);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd7;
        bus.wr_data  = 32'hDEADBEEF;
        bus.wr_be    = 4'b1111;
        bus.dbg_addr = 5'd7;
        read(5'd7, 5'd7);
        bus.wr_en = 1'b0;
        check_eq("bypass_a", bus.ra_data, 32'hDEADBEEF);
        check_eq("bypass_b", bus.rb_data, 32'hDEADBEEF);
        check_eq("bypass_dbg", bus.dbg_data, 32'h01020304);
        bus.dbg_addr = '0;

        // Register 0 ignores writes without flagging a drop.
        write(5'd0, 32'h12345678, 4'b1111);
        read(5'd0, 5'd0);
        check_eq("zero_reg", bus.ra_data, 0);
        check_eq("zero_nodrop", bus.wr_drop, 0);

        // Write during sweep index 3 is dropped and sticky.
        write(5'd9, 32'h5555AAAA, 4'b1111);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        write(5'd9, 32'hCAFEF00D, 4'b1111);
        wait_sweep(n);
        read(5'd9, 5'd9);
        check_eq("drop_target", bus.ra_data, 0);
        check_eq("drop_flag", bus.wr_drop, 1);

        // Reset at sweep index 20 restarts a full sweep; reads stay invalid throughout.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rd_en = 1'b1;
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_sweep(n);
        check_eq("restart_len", n, DEPTH);
        bus.rd_en = 1'b0;

        // Random traffic, biased to low addresses so bypass hits are common.
        for (int c = 0; c < 800; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            bus.rd_en    = ($urandom_range(0, 2) != 0);
            bus.wr_en    = ($urandom_range(0, 1) != 0);
            bus.ra_addr  = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            bus.rb_addr  = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            bus.wr_addr  = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            bus.dbg_addr = AW'($urandom_range(0, 31));
            bus.wr_data  = $urandom;
            bus.wr_be    = 4'($urandom_range(0, 15));
            step();
        end
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
